cxu_accum_unit: RTL and testbench
=================================

// Module: cxu_accum_unit
// PURPOSE
// - Composable custom-function unit on the core's exported CXU request/response port; directly downstream of the CPU-side CXU master.
// - Keeps one 32-bit accumulator per CXU state context (2**STATE_W contexts).
// - Executes MAC/READ/WRITE/CLEAR functions.
// - Returns in-order tagged responses through a response FIFO with backpressure.
// PARAMETERS
// - REQ_ID_W    4   width of request/response tag
// - CXU_ID_W    4   width of CXU select field
// - STATE_W     2   width of state-context index
// - FUNC_W      3   width of function code
// - INSN_W      32  width of raw instruction field
// - DATA_W      32  operand/result width
// - STATUS_W    2   response status width
// - CXU_ID      0   CXU select value this unit answers to
// - RESP_DEPTH  4   response FIFO entries; power of two, >=2
// PORTS
// - clk              in   1         clock
// - rst              in   1         synchronous active-high reset
// - cxu_req_valid    in   1         request valid
// - cxu_req_ready    out  1         request ready
// - cxu_req_id       in   REQ_ID_W  request tag
// - cxu_req_cxu      in   CXU_ID_W  CXU select
// - cxu_req_state    in   STATE_W   context index
// - cxu_req_func     in   FUNC_W    function code
// - cxu_req_insn     in   INSN_W    raw instruction; ignored
// - cxu_req_data0    in   DATA_W    operand A
// - cxu_req_data1    in   DATA_W    operand B
// - cxu_resp_valid   out  1         response valid
// - cxu_resp_ready   in   1         response ready
// - cxu_resp_id      out  REQ_ID_W  echoed tag
// - cxu_resp_status  out  STATUS_W  0=OK, 1=BAD_FUNC, 2=BAD_CXU
// - cxu_resp_data    out  DATA_W    result
// BEHAVIOUR
// - Single clock clk; reset rst is synchronous, active-high.
// - Reset values:
//   - cxu_req_ready = 1; cxu_resp_valid = 0.
//   - cxu_resp_id/status/data = 0; all accumulators = 0; FIFO count = 0.
// - Accept: a request is accepted when cxu_req_valid && cxu_req_ready at a rising edge.
// - cxu_req_ready = (fifo_count < RESP_DEPTH). It is a function of registered count only, with no combinational path from resp_ready.
//   - When full, a pop frees a slot next cycle.
// - Execute on the accept edge. Let s = req_state, A = data0, B = data1.
//   - func 0 MAC:   acc[s] <= acc[s] + A*B (low DATA_W bits of unsigned product); data = new acc[s].
//   - func 1 READ:  data = acc[s]; no update.
//   - func 2 WRITE: acc[s] <= A; data = old acc[s].
//   - func 3 CLEAR: acc[s] <= 0; data = 0.
//   - func >=4:     status = 1, data = 0, no update.
//   - req_cxu != CXU_ID: status = 2, data = 0, no update. This check takes precedence over the func check.
// - Back-to-back requests to the same context see the prior result; each update completes at its accept edge.
// - Latency: the response is pushed on the accept edge, so cxu_resp_valid is high the cycle after accept at the earliest.
// - Responses are strictly in accept order.
// - Response port:
//   - Outputs are the FIFO head, driven from registers.
//   - A pop occurs on cxu_resp_valid && cxu_resp_ready.
//   - While valid && !ready, id/status/data hold stable.
//   - Simultaneous push and pop leaves the count unchanged.
//   - Head and tail pointers wrap modulo RESP_DEPTH.
// - Reset mid-operation clears the FIFO and all accumulators in the same cycle. Pending responses are discarded.
// - Throughput: one request per cycle while the FIFO is not full.
// CONFIGURATION
// - Macro CXU_ACCUM_SAT_EN defined:
//   - MAC treats acc, A and B as signed.
//   - The full 2*DATA_W signed product is added to sign-extended acc.
//   - The result saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
// - Macro undefined: MAC is unsigned modulo 2**DATA_W (wrap-around). No saturation logic is compiled.
// TESTING
// - WRITE s=1 A=5; then MAC s=1 A=3 B=4 -> responses: data=0 (old), then data=17, both status=0; ids echoed.
// - Hold resp_ready=0; issue 4 READs ids 0..3:
//   - req_ready drops after 4th accept.
//   - Raise resp_ready -> ids 0,1,2,3 in order; req_ready=1 the cycle after first pop.
// - func=5, then req_cxu=CXU_ID+1 with func=0 -> status=1 then status=2, data=0; acc unchanged (READ confirms).
// - Back-to-back MAC s=0 A=2 B=2 for 3 cycles -> data 4, 8, 12. Simultaneous push/pop keeps count stable.
// - WRITE s=2 A=32'hFFFFFFFF; MAC s=2 A=1 B=1:
//   - SAT_EN off -> data=0.
//   - SAT_EN on  -> data=0 (-1+1).
//   - With SAT_EN on, WRITE 32'h7FFFFFFF then MAC 1*1 -> 32'h7FFFFFFF.
// - Assert rst for 1 cycle with 2 pending responses -> resp_valid=0 next cycle; READ of any context returns 0.

Source files
------------

// File: rtl/cxu_accum_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cxu_accum_unit
//  Purpose  : Composable custom-function unit on the CXU request/response
//             port. It keeps one DATA_W accumulator per state context
//             (2**STATE_W contexts) and executes MAC / READ / WRITE / CLEAR.
//             Tagged responses return in accept order through a response
//             FIFO with backpressure.
//  Ports    : clk, rst (sync, active-high)
//             cxu_req_*  : valid/ready request channel (id, cxu, state,
//                          func, insn (ignored), data0 = A, data1 = B)
//             cxu_resp_* : valid/ready response channel (id, status, data)
//                          status 0=OK, 1=BAD_FUNC, 2=BAD_CXU
//  Config   : CXU_ACCUM_SAT_EN - when defined, MAC is signed and saturating.
//             Otherwise MAC is unsigned and wraps modulo 2**DATA_W.
//  Revision : 1.0 - initial release
// ============================================================================
module cxu_accum_unit #(
  parameter int REQ_ID_W   = 4,
  parameter int CXU_ID_W   = 4,
  parameter int STATE_W    = 2,
  parameter int FUNC_W     = 3,
  parameter int INSN_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STATUS_W   = 2,
  parameter int CXU_ID     = 0,
  parameter int RESP_DEPTH = 4    // power of two, >= 2
) (
  input  logic                clk,
  input  logic                rst,
  // request channel
  input  logic                cxu_req_valid,
  output logic                cxu_req_ready,
  input  logic [REQ_ID_W-1:0] cxu_req_id,
  input  logic [CXU_ID_W-1:0] cxu_req_cxu,
  input  logic [STATE_W-1:0]  cxu_req_state,
  input  logic [FUNC_W-1:0]   cxu_req_func,
  input  logic [INSN_W-1:0]   cxu_req_insn,
  input  logic [DATA_W-1:0]   cxu_req_data0,
  input  logic [DATA_W-1:0]   cxu_req_data1,
  // response channel
  output logic                cxu_resp_valid,
  input  logic                cxu_resp_ready,
  output logic [REQ_ID_W-1:0] cxu_resp_id,
  output logic [STATUS_W-1:0] cxu_resp_status,
  output logic [DATA_W-1:0]   cxu_resp_data
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NCTX  = 2 ** STATE_W;

  localparam logic [CNT_W-1:0]    DEPTH_C   = CNT_W'(RESP_DEPTH);
  localparam logic [CXU_ID_W-1:0] CXU_SEL   = CXU_ID_W'(CXU_ID);

  localparam logic [FUNC_W-1:0]   FN_MAC    = FUNC_W'(0);
  localparam logic [FUNC_W-1:0]   FN_READ   = FUNC_W'(1);
  localparam logic [FUNC_W-1:0]   FN_WRITE  = FUNC_W'(2);
  localparam logic [FUNC_W-1:0]   FN_CLEAR  = FUNC_W'(3);

  localparam logic [STATUS_W-1:0] ST_OK       = STATUS_W'(0);
  localparam logic [STATUS_W-1:0] ST_BAD_FUNC = STATUS_W'(1);
  localparam logic [STATUS_W-1:0] ST_BAD_CXU  = STATUS_W'(2);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]   acc_q [NCTX];
  logic [DATA_W-1:0]   acc_d [NCTX];

  logic [REQ_ID_W-1:0] fifo_id_q     [RESP_DEPTH];
  logic [STATUS_W-1:0] fifo_status_q [RESP_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q   [RESP_DEPTH];

  logic [PTR_W-1:0]    head_q;
  logic [PTR_W-1:0]    tail_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;

  // The raw instruction word carries nothing this unit decodes.
  logic                w_unused_insn;
  assign w_unused_insn = ^cxu_req_insn;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_pop;

  // Ready depends only on the registered count, so there is no path from
  // cxu_resp_ready to cxu_req_ready; a pop while full frees a slot next cycle.
  assign cxu_req_ready  = (count_q < DEPTH_C);
  assign cxu_resp_valid = (count_q != '0);
  assign w_accept       = cxu_req_valid & cxu_req_ready;
  assign w_pop          = cxu_resp_valid & cxu_resp_ready;

  // --------------------------------------------------------------------------
  // MAC datapath
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_acc_old;
  logic [DATA_W-1:0] w_mac_res;

  assign w_acc_old = acc_q[cxu_req_state];

`ifdef CXU_ACCUM_SAT_EN
  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] w_prod;
  logic        [PW:0]   w_sum;
  logic                 w_ovf;

  // Full-width signed product; (-2**(DATA_W-1))**2 still fits in PW bits.
  assign w_prod = PW'($signed(cxu_req_data0)) * PW'($signed(cxu_req_data1));

  // One extra bit of headroom so the sum of the product and the
  // sign-extended accumulator can never wrap.
  assign w_sum  = {w_prod[PW-1], w_prod}
                + {{(DATA_W + 1){w_acc_old[DATA_W-1]}}, w_acc_old};

  // The result fits in DATA_W signed bits only when every bit from the
  // DATA_W-1 position upward is a copy of the sign.
  assign w_ovf  = ~((&w_sum[PW:DATA_W-1]) | ~(|w_sum[PW:DATA_W-1]));

  always_comb begin
    w_mac_res = w_sum[DATA_W-1:0];
    if (w_ovf) begin
      w_mac_res = w_sum[PW] ? {1'b1, {(DATA_W - 1){1'b0}}}
                            : {1'b0, {(DATA_W - 1){1'b1}}};
    end
  end
`else
  logic [DATA_W-1:0] w_prod_lo;

  // Only the low DATA_W bits of the unsigned product matter for a
  // modulo-2**DATA_W accumulate.
  assign w_prod_lo = cxu_req_data0 * cxu_req_data1;
  assign w_mac_res = w_acc_old + w_prod_lo;
`endif

  // --------------------------------------------------------------------------
  // Function decode
  // --------------------------------------------------------------------------
  logic [STATUS_W-1:0] w_status;
  logic [DATA_W-1:0]   w_data;
  logic                w_acc_we;
  logic [DATA_W-1:0]   w_acc_wdata;

  always_comb begin
    w_status    = ST_OK;
    w_data      = '0;
    w_acc_we    = 1'b0;
    w_acc_wdata = '0;
    // A request for another CXU is rejected before the function is examined.
    if (cxu_req_cxu != CXU_SEL) begin
      w_status = ST_BAD_CXU;
    end else begin
      case (cxu_req_func)
        FN_MAC: begin
          w_data      = w_mac_res;
          w_acc_we    = 1'b1;
          w_acc_wdata = w_mac_res;
        end
        FN_READ: begin
          w_data = w_acc_old;
        end
        FN_WRITE: begin
          w_data      = w_acc_old;
          w_acc_we    = 1'b1;
          w_acc_wdata = cxu_req_data0;
        end
        FN_CLEAR: begin
          w_acc_we    = 1'b1;
          w_acc_wdata = '0;
        end
        default: begin
          w_status = ST_BAD_FUNC;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator next state: the update lands on the accept edge, so the
  // next back-to-back request to the same context sees it.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NCTX; i++) begin
      acc_d[i] = acc_q[i];
    end
    if (w_accept && w_acc_we) begin
      acc_d[cxu_req_state] = w_acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCTX; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCTX; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    case ({w_accept, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;   // idle, or push and pop together
    endcase
  end

  // Storage is cleared on reset so the head outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_id_q[i]     <= '0;
        fifo_status_q[i] <= '0;
        fifo_data_q[i]   <= '0;
      end
    end else begin
      // Accept already implies a free slot, so a push never overwrites.
      if (w_accept) begin
        fifo_id_q[tail_q]     <= cxu_req_id;
        fifo_status_q[tail_q] <= w_status;
        fifo_data_q[tail_q]   <= w_data;
        tail_q                <= tail_q + PTR_W'(1);
      end
      if (w_pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Head entry is read straight out of the storage registers and only moves
  // on a pop, so it stays stable while the consumer stalls.
  assign cxu_resp_id     = fifo_id_q[head_q];
  assign cxu_resp_status = fifo_status_q[head_q];
  assign cxu_resp_data   = fifo_data_q[head_q];

endmodule
`default_nettype wire

// File: tb/tb_cxu_accum_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cxu_accum_unit
//  Purpose  : Directed self-checking bench for cxu_accum_unit. Responses are
//             captured as they are handshaked and compared against
//             hand-computed expected values.
//  Config   : CXU_ACCUM_SAT_EN selects the saturating MAC expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cxu_accum_unit;

  localparam logic [2:0] FN_MAC   = 3'd0;
  localparam logic [2:0] FN_READ  = 3'd1;
  localparam logic [2:0] FN_WRITE = 3'd2;
  localparam logic [2:0] FN_CLEAR = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cxu_req_valid;
  logic        cxu_req_ready;
  logic [3:0]  cxu_req_id;
  logic [3:0]  cxu_req_cxu;
  logic [1:0]  cxu_req_state;
  logic [2:0]  cxu_req_func;
  logic [31:0] cxu_req_insn;
  logic [31:0] cxu_req_data0;
  logic [31:0] cxu_req_data1;
  logic        cxu_resp_valid;
  logic        cxu_resp_ready;
  logic [3:0]  cxu_resp_id;
  logic [1:0]  cxu_resp_status;
  logic [31:0] cxu_resp_data;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  st;
    logic [31:0] d;
  } resp_t;

  resp_t rq[$];

  cxu_accum_unit dut (
    .clk             (clk),
    .rst             (rst),
    .cxu_req_valid   (cxu_req_valid),
    .cxu_req_ready   (cxu_req_ready),
    .cxu_req_id      (cxu_req_id),
    .cxu_req_cxu     (cxu_req_cxu),
    .cxu_req_state   (cxu_req_state),
    .cxu_req_func    (cxu_req_func),
    .cxu_req_insn    (cxu_req_insn),
    .cxu_req_data0   (cxu_req_data0),
    .cxu_req_data1   (cxu_req_data1),
    .cxu_resp_valid  (cxu_resp_valid),
    .cxu_resp_ready  (cxu_resp_ready),
    .cxu_resp_id     (cxu_resp_id),
    .cxu_resp_status (cxu_resp_status),
    .cxu_resp_data   (cxu_resp_data)
  );

  always #5 clk = ~clk;

  // Capture each response that will be popped at the coming rising edge.
  always begin
    @(negedge clk);
    #1;
    if (cxu_resp_valid && cxu_resp_ready) begin
      rq.push_back('{id: cxu_resp_id, st: cxu_resp_status, d: cxu_resp_data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input logic [3:0] id, input logic [3:0] cxu, input logic [1:0] st,
                       input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    cxu_req_valid = 1'b1;
    cxu_req_id    = id;
    cxu_req_cxu   = cxu;
    cxu_req_state = st;
    cxu_req_func  = fn;
    cxu_req_insn  = 32'hDEAD_BEEF;
    cxu_req_data0 = a;
    cxu_req_data1 = b;
    while (!cxu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("req_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cxu_req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [3:0] id,
                             input logic [1:0] st, input logic [31:0] d);
    int    n = 0;
    resp_t r;
    while (rq.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r = rq.pop_front();
      chk({tag, "_id"},     32'(r.id), 32'(id));
      chk({tag, "_status"}, 32'(r.st), 32'(st));
      chk({tag, "_data"},   r.d,       d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    cxu_req_valid  = 1'b0;
    cxu_req_id     = '0;
    cxu_req_cxu    = '0;
    cxu_req_state  = '0;
    cxu_req_func   = '0;
    cxu_req_insn   = '0;
    cxu_req_data0  = '0;
    cxu_req_data1  = '0;
    cxu_resp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req_ready",   32'(cxu_req_ready),   32'd1);
    chk("rst_resp_valid",  32'(cxu_resp_valid),  32'd0);
    chk("rst_resp_id",     32'(cxu_resp_id),     32'd0);
    chk("rst_resp_status", 32'(cxu_resp_status), 32'd0);
    chk("rst_resp_data",   cxu_resp_data,        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // WRITE then MAC on context 1: 5 + 3*4 = 17
    issue(4'd1, 4'd0, 2'd1, FN_WRITE, 32'd5, 32'd0);
    issue(4'd2, 4'd0, 2'd1, FN_MAC,   32'd3, 32'd4);
    expect_resp("wr_old", 4'd1, 2'd0, 32'd0);
    expect_resp("mac17",  4'd2, 2'd0, 32'd17);

    // Fill the FIFO under backpressure
    cxu_resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 4'd0, 2'd1, FN_READ, 32'd0, 32'd0);
    end
    chk("full_req_ready",  32'(cxu_req_ready),  32'd0);
    chk("full_resp_valid", 32'(cxu_resp_valid), 32'd1);
    chk("full_head_id",    32'(cxu_resp_id),    32'd0);
    @(negedge clk);
    chk("hold_head_id",    32'(cxu_resp_id),    32'd0);
    chk("hold_head_data",  cxu_resp_data,       32'd17);
    chk("hold_req_ready",  32'(cxu_req_ready),  32'd0);
    cxu_resp_ready = 1'b1;
    @(negedge clk);
    chk("pop_req_ready",   32'(cxu_req_ready),  32'd1);
    for (int i = 0; i < 4; i++) begin
      expect_resp($sformatf("order%0d", i), 4'(i), 2'd0, 32'd17);
    end

    // Bad function, then wrong CXU (takes precedence), accumulators untouched
    issue(4'd5, 4'd0, 2'd1, 3'd5,   32'd9, 32'd9);
    issue(4'd6, 4'd1, 2'd1, FN_MAC, 32'd9, 32'd9);
    issue(4'd7, 4'd0, 2'd1, FN_READ, 32'd0, 32'd0);
    issue(4'd8, 4'd1, 2'd1, 3'd6,   32'd9, 32'd9);
    expect_resp("bad_func", 4'd5, 2'd1, 32'd0);
    expect_resp("bad_cxu",  4'd6, 2'd2, 32'd0);
    expect_resp("unchg",    4'd7, 2'd0, 32'd17);
    expect_resp("cxu_prec", 4'd8, 2'd2, 32'd0);

    // Back-to-back MACs on context 0
    issue(4'd9,  4'd0, 2'd0, FN_MAC, 32'd2, 32'd2);
    issue(4'd10, 4'd0, 2'd0, FN_MAC, 32'd2, 32'd2);
    issue(4'd11, 4'd0, 2'd0, FN_MAC, 32'd2, 32'd2);
    chk("b2b_req_ready", 32'(cxu_req_ready), 32'd1);
    expect_resp("b2b_4",  4'd9,  2'd0, 32'd4);
    expect_resp("b2b_8",  4'd10, 2'd0, 32'd8);
    expect_resp("b2b_12", 4'd11, 2'd0, 32'd12);
    @(negedge clk);
    chk("b2b_drained", 32'(cxu_resp_valid), 32'd0);

    // CLEAR on context 3 after loading it
    issue(4'd12, 4'd0, 2'd3, FN_WRITE, 32'hA5A5_0001, 32'd0);
    issue(4'd13, 4'd0, 2'd3, FN_CLEAR, 32'd0, 32'd0);
    issue(4'd14, 4'd0, 2'd3, FN_READ,  32'd0, 32'd0);
    expect_resp("clr_wr",   4'd12, 2'd0, 32'd0);
    expect_resp("clr",      4'd13, 2'd0, 32'd0);
    expect_resp("clr_read", 4'd14, 2'd0, 32'd0);

    // Boundary accumulate on context 2
    issue(4'd1, 4'd0, 2'd2, FN_WRITE, 32'hFFFF_FFFF, 32'd0);
    issue(4'd2, 4'd0, 2'd2, FN_MAC,   32'd1, 32'd1);
    issue(4'd3, 4'd0, 2'd2, FN_WRITE, 32'h7FFF_FFFF, 32'd0);
    issue(4'd4, 4'd0, 2'd2, FN_MAC,   32'd1, 32'd1);
    expect_resp("wr_ff",    4'd1, 2'd0, 32'd0);
    expect_resp("mac_wrap", 4'd2, 2'd0, 32'd0);
    expect_resp("wr_7f",    4'd3, 2'd0, 32'd0);
`ifdef CXU_ACCUM_SAT_EN
    expect_resp("mac_max",  4'd4, 2'd0, 32'h7FFF_FFFF);
`else
    expect_resp("mac_max",  4'd4, 2'd0, 32'h8000_0000);
`endif

    // Reset with two responses pending
    cxu_resp_ready = 1'b0;
    issue(4'd14, 4'd0, 2'd1, FN_READ, 32'd0, 32'd0);
    issue(4'd15, 4'd0, 2'd0, FN_READ, 32'd0, 32'd0);
    chk("pend_resp_valid", 32'(cxu_resp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(cxu_resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(cxu_req_ready),  32'd1);
    chk("no_stale",      32'(rq.size()),      32'd0);
    cxu_resp_ready = 1'b1;
    issue(4'd1, 4'd0, 2'd0, FN_READ, 32'd0, 32'd0);
    issue(4'd2, 4'd0, 2'd1, FN_READ, 32'd0, 32'd0);
    issue(4'd3, 4'd0, 2'd2, FN_READ, 32'd0, 32'd0);
    expect_resp("rst_acc0", 4'd1, 2'd0, 32'd0);
    expect_resp("rst_acc1", 4'd2, 2'd0, 32'd0);
    expect_resp("rst_acc2", 4'd3, 2'd0, 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
